da_sequencer: RTL and testbench

- Bit-serial scheduler for the distributed-arithmetic (DA) engine, running in the fast clock domain.
- On each start pulse from the slow-domain control path:
  - clears the accumulator;
  - issues DATA_W LUT reads, one per input-bit plane, LSB first;
  - asserts accumulate enables aligned to LUT_LAT;
  - flags the sign-bit subtract;
  - pulses done.
- Arbitrates the shared coefficient LUT between sample processing and coefficient-load requests, so coefficients are never rewritten mid-computation.

---
 rtl/da_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_da_sequencer.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/da_sequencer.sv
// Bit-serial distributed-arithmetic scheduler with shared coefficient-LUT arbitration.
// Define DA_SEQ_OVR_CNT_EN to add o_ovr_cnt, a saturating count of dropped starts.

module da_sequencer #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned LUT_LAT = 1,
  parameter int unsigned BIT_W   = 4
) (
  input  logic             i_clk,
  input  logic             i_resetn,
  input  logic             i_start,
  input  logic             i_cload_req,
  output logic             o_cload_gnt,
  input  logic             i_ovr_clr,
  output logic             o_busy,
  output logic             o_acc_clr,
  output logic             o_lut_rd_en,
  output logic [BIT_W-1:0] o_bit_sel,
  output logic             o_acc_en,
  output logic             o_acc_sub,
  output logic             o_done,
  output logic             o_overrun
`ifdef DA_SEQ_OVR_CNT_EN
  ,
  output logic [7:0]       o_ovr_cnt
`endif
);

  if (LUT_LAT > 3) begin : g_bad_lat
    $error("da_sequencer: LUT_LAT must be in 0..3");
  end
  if ((1 << BIT_W) < DATA_W) begin : g_bad_bit_w
    $error("da_sequencer: BIT_W too narrow for DATA_W");
  end

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StClear,
    StAccum,
    StDrain,
    StDone
  } state_e;

  localparam logic [BIT_W-1:0] LastBit   = BIT_W'(DATA_W - 1);
  localparam logic [1:0]       DrainLast = 2'(LUT_LAT - 1);

  state_e           r_state;
  state_e           w_state_d;
  logic [BIT_W-1:0] r_bit_sel;
  logic [BIT_W-1:0] w_bit_sel_d;
  logic [1:0]       r_drain_cnt;
  logic [1:0]       w_drain_cnt_d;
  logic             w_last_bit;
  logic             w_rd_en;
  logic             w_sub_tap;
  logic             w_drop;
  logic             r_overrun;

  assign w_last_bit = (r_bit_sel == LastBit);

  always_comb begin
    w_state_d     = r_state;
    w_bit_sel_d   = r_bit_sel;
    w_drain_cnt_d = r_drain_cnt;
    case (r_state)
      StIdle: begin
        // A start outranks a pending coefficient load.
        if (i_start) begin
          w_state_d   = StClear;
          w_bit_sel_d = '0;
        end else if (i_cload_req) begin
          w_state_d = StLoad;
        end
      end
      StLoad: begin
        if (!i_cload_req) begin
          w_state_d = StIdle;
        end
      end
      StClear: begin
        w_state_d = StAccum;
      end
      StAccum: begin
        if (w_last_bit) begin
          if (LUT_LAT > 0) begin
            w_state_d     = StDrain;
            w_drain_cnt_d = '0;
          end else begin
            w_state_d = StDone;
          end
        end else begin
          w_bit_sel_d = r_bit_sel + BIT_W'(1);
        end
      end
      StDrain: begin
        if (r_drain_cnt == DrainLast) begin
          w_state_d = StDone;
        end else begin
          w_drain_cnt_d = r_drain_cnt + 2'd1;
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state     <= StIdle;
      r_bit_sel   <= '0;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_d;
      r_bit_sel   <= w_bit_sel_d;
      r_drain_cnt <= w_drain_cnt_d;
    end
  end

  assign w_rd_en   = (r_state == StAccum);
  assign w_sub_tap = w_rd_en && w_last_bit;

  assign o_busy      = (r_state != StIdle);
  assign o_cload_gnt = (r_state == StLoad);
  assign o_acc_clr   = (r_state == StClear);
  assign o_lut_rd_en = w_rd_en;
  assign o_bit_sel   = r_bit_sel;
  assign o_done      = (r_state == StDone);

  // Accumulate enables trail the reads by the LUT read latency.
  if (LUT_LAT == 0) begin : g_no_lat
    assign o_acc_en  = w_rd_en;
    assign o_acc_sub = w_sub_tap;
  end else begin : g_lat
    logic [LUT_LAT-1:0] r_en_pipe;
    logic [LUT_LAT-1:0] r_sub_pipe;

    always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
        r_en_pipe  <= '0;
        r_sub_pipe <= '0;
      end else begin
        r_en_pipe[0]  <= w_rd_en;
        r_sub_pipe[0] <= w_sub_tap;
        for (int k = 1; k < int'(LUT_LAT); k++) begin
          r_en_pipe[k]  <= r_en_pipe[k-1];
          r_sub_pipe[k] <= r_sub_pipe[k-1];
        end
      end
    end

    assign o_acc_en  = r_en_pipe[LUT_LAT-1];
    assign o_acc_sub = r_sub_pipe[LUT_LAT-1];
  end

  assign w_drop = i_start && (r_state != StIdle);

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (i_ovr_clr) begin
      r_overrun <= 1'b0;
    end
  end

  assign o_overrun = r_overrun;

`ifdef DA_SEQ_OVR_CNT_EN
  logic [7:0] r_ovr_cnt;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_ovr_cnt <= 8'd0;
    end else if (w_drop) begin
      if (i_ovr_clr) begin
        r_ovr_cnt <= 8'd1;
      end else if (r_ovr_cnt != 8'hFF) begin
        r_ovr_cnt <= r_ovr_cnt + 8'd1;
      end
    end else if (i_ovr_clr) begin
      r_ovr_cnt <= 8'd0;
    end
  end

  assign o_ovr_cnt = r_ovr_cnt;
`endif

endmodule

// File: tb/tb_da_sequencer.sv
// Bench for da_sequencer: LUT_LAT=1 and LUT_LAT=0 instances share stimulus and are
// checked every cycle against a timeline model, plus directed literal checks.

module tb_da_sequencer;

  localparam int DATA_W = 16;
  localparam int BIT_W  = 4;

  logic clk = 1'b0;
  logic resetn;
  logic start;
  logic cload_req;
  logic ovr_clr;

  logic             d_busy[2];
  logic             d_gnt[2];
  logic             d_clr[2];
  logic             d_rd[2];
  logic [BIT_W-1:0] d_bs[2];
  logic             d_en[2];
  logic             d_sub[2];
  logic             d_done[2];
  logic             d_ovr[2];
`ifdef DA_SEQ_OVR_CNT_EN
  logic [7:0]       d_cnt[2];
`endif

  always #5 clk = ~clk;

  da_sequencer #(.DATA_W(DATA_W), .LUT_LAT(1), .BIT_W(BIT_W)) u_dut_l1 (
    .i_clk       (clk),
    .i_resetn    (resetn),
    .i_start     (start),
    .i_cload_req (cload_req),
    .o_cload_gnt (d_gnt[0]),
    .i_ovr_clr   (ovr_clr),
    .o_busy      (d_busy[0]),
    .o_acc_clr   (d_clr[0]),
    .o_lut_rd_en (d_rd[0]),
    .o_bit_sel   (d_bs[0]),
    .o_acc_en    (d_en[0]),
    .o_acc_sub   (d_sub[0]),
    .o_done      (d_done[0]),
    .o_overrun   (d_ovr[0])
`ifdef DA_SEQ_OVR_CNT_EN
    ,
    .o_ovr_cnt   (d_cnt[0])
`endif
  );

  da_sequencer #(.DATA_W(DATA_W), .LUT_LAT(0), .BIT_W(BIT_W)) u_dut_l0 (
    .i_clk       (clk),
    .i_resetn    (resetn),
    .i_start     (start),
    .i_cload_req (cload_req),
    .o_cload_gnt (d_gnt[1]),
    .i_ovr_clr   (ovr_clr),
    .o_busy      (d_busy[1]),
    .o_acc_clr   (d_clr[1]),
    .o_lut_rd_en (d_rd[1]),
    .o_bit_sel   (d_bs[1]),
    .o_acc_en    (d_en[1]),
    .o_acc_sub   (d_sub[1]),
    .o_done      (d_done[1]),
    .o_overrun   (d_ovr[1])
`ifdef DA_SEQ_OVR_CNT_EN
    ,
    .o_ovr_cnt   (d_cnt[1])
`endif
  );

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  // Model: mode 0 idle, 1 coefficient load, 2 running; t counts cycles since the start.
  int m_mode[2];
  int m_t[2];
  int m_bl[2];
  int m_cnt[2];
  bit m_ovr[2];

  always @(posedge clk or negedge resetn) begin
    for (int i = 0; i < 2; i++) begin
      if (!resetn) begin
        m_mode[i] <= 0;
        m_t[i]    <= 0;
        m_bl[i]   <= 0;
        m_cnt[i]  <= 0;
        m_ovr[i]  <= 1'b0;
      end else begin
        if (start && m_mode[i] != 0) begin
          m_ovr[i] <= 1'b1;
          m_cnt[i] <= ovr_clr ? 1 : ((m_cnt[i] >= 255) ? 255 : m_cnt[i] + 1);
        end else if (ovr_clr) begin
          m_ovr[i] <= 1'b0;
          m_cnt[i] <= 0;
        end
        case (m_mode[i])
          0: begin
            if (start) begin
              m_mode[i] <= 2;
              m_t[i]    <= 1;
              m_bl[i]   <= 0;
            end else if (cload_req) begin
              m_mode[i] <= 1;
            end
          end
          1: if (!cload_req) m_mode[i] <= 0;
          default: begin
            if (m_t[i] == DATA_W + 2 + lat_of(i)) begin
              m_mode[i] <= 0;
              m_bl[i]   <= DATA_W - 1;
            end else begin
              m_t[i] <= m_t[i] + 1;
            end
          end
        endcase
      end
    end
  end

  int n_vec  = 0;
  int n_fail = 0;
  int rel    = 0;

  logic [39:0] tr_busy[2];
  logic [39:0] tr_gnt[2];
  logic [39:0] tr_clr[2];
  logic [39:0] tr_rd[2];
  logic [39:0] tr_en[2];
  logic [39:0] tr_sub[2];
  logic [39:0] tr_done[2];
  logic [39:0] tr_ovr[2];
  int          tr_bs[2][40];

  task automatic check(input string name, input int dut, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s dut%0d t=%0t: got %0d, expected %0d", name, dut, $time, act, exp);
    end
  endtask

  function automatic int first_hi(input logic [39:0] v);
    for (int k = 0; k < 40; k++) if (v[k]) return k;
    return -1;
  endfunction

  function automatic int last_hi(input logic [39:0] v);
    for (int k = 39; k >= 0; k--) if (v[k]) return k;
    return -1;
  endfunction

  task automatic clear_tr();
    for (int i = 0; i < 2; i++) begin
      tr_busy[i] = '0; tr_gnt[i] = '0; tr_clr[i] = '0; tr_rd[i] = '0;
      tr_en[i] = '0; tr_sub[i] = '0; tr_done[i] = '0; tr_ovr[i] = '0;
      for (int k = 0; k < 40; k++) tr_bs[i][k] = 0;
    end
    rel = 0;
  endtask

  // Compare both DUTs with the model mid-cycle, record traces, advance one cycle.
  task automatic cyc();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      int md;
      int t;
      int lt;
      bit run;
      int e_bs;
      md  = m_mode[i];
      t   = m_t[i];
      lt  = lat_of(i);
      run = (md == 2);
      if (!run) e_bs = m_bl[i];
      else if (t < 2) e_bs = 0;
      else e_bs = (t - 2 > DATA_W - 1) ? DATA_W - 1 : t - 2;
      check("busy", i, longint'(d_busy[i]), longint'(md != 0));
      check("cload_gnt", i, longint'(d_gnt[i]), longint'(md == 1));
      check("acc_clr", i, longint'(d_clr[i]), longint'(run && t == 1));
      check("lut_rd_en", i, longint'(d_rd[i]), longint'(run && t >= 2 && t <= DATA_W + 1));
      check("bit_sel", i, longint'(d_bs[i]), longint'(e_bs));
      check("acc_en", i, longint'(d_en[i]),
            longint'(run && t >= 2 + lt && t <= DATA_W + 1 + lt));
      check("acc_sub", i, longint'(d_sub[i]), longint'(run && t == DATA_W + 1 + lt));
      check("done", i, longint'(d_done[i]), longint'(run && t == DATA_W + 2 + lt));
      check("overrun", i, longint'(d_ovr[i]), longint'(m_ovr[i]));
`ifdef DA_SEQ_OVR_CNT_EN
      check("ovr_cnt", i, longint'(d_cnt[i]), longint'(m_cnt[i]));
`endif
      if (rel >= 0 && rel < 40) begin
        tr_busy[i][rel] = d_busy[i];
        tr_gnt[i][rel]  = d_gnt[i];
        tr_clr[i][rel]  = d_clr[i];
        tr_rd[i][rel]   = d_rd[i];
        tr_en[i][rel]   = d_en[i];
        tr_sub[i][rel]  = d_sub[i];
        tr_done[i][rel] = d_done[i];
        tr_ovr[i][rel]  = d_ovr[i];
        tr_bs[i][rel]   = int'(d_bs[i]);
      end
    end
    @(posedge clk);
    #2;
    rel++;
  endtask

  task automatic check_zero(input string name);
    for (int i = 0; i < 2; i++) begin
      check({name, "_busy"}, i, longint'(d_busy[i]), 0);
      check({name, "_rd"}, i, longint'(d_rd[i]), 0);
      check({name, "_bitsel"}, i, longint'(d_bs[i]), 0);
      check({name, "_acc_en"}, i, longint'(d_en[i]), 0);
      check({name, "_done"}, i, longint'(d_done[i]), 0);
      check({name, "_overrun"}, i, longint'(d_ovr[i]), 0);
    end
  endtask

  initial begin
    resetn    = 1'b0;
    start     = 1'b0;
    cload_req = 1'b0;
    ovr_clr   = 1'b0;
    @(posedge clk);
    #2;
    check_zero("reset");
    @(posedge clk);
    #2;
    resetn = 1'b1;
    repeat (3) cyc();

    // Single sample from idle.
    clear_tr();
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (29) cyc();
    check("A_acc_clr", 0, longint'(tr_clr[0]), 64'h1 << 1);
    check("A_done", 0, longint'(tr_done[0]), 64'h1 << 19);
    check("A_acc_sub", 0, longint'(tr_sub[0]), 64'h1 << 18);
    check("A_en_first", 0, first_hi(tr_en[0]), 3);
    check("A_en_last", 0, last_hi(tr_en[0]), 18);
    check("A_en_count", 0, $countones(tr_en[0]), 16);
    check("A_rd_first", 0, first_hi(tr_rd[0]), 2);
    check("A_rd_last", 0, last_hi(tr_rd[0]), 17);
    check("A_busy", 0, longint'(tr_busy[0]), 64'hF_FFFE);
    check("A_bs_c2", 0, tr_bs[0][2], 0);
    check("A_bs_c17", 0, tr_bs[0][17], 15);
    check("A_bs_drain", 0, tr_bs[0][18], 15);
    check("A_done", 1, longint'(tr_done[1]), 64'h1 << 18);
    check("A_acc_sub", 1, longint'(tr_sub[1]), 64'h1 << 17);
    check("A_en_first", 1, first_hi(tr_en[1]), 2);
    check("A_en_last", 1, last_hi(tr_en[1]), 17);
    check("A_en_count", 1, $countones(tr_en[1]), 16);
    check("A_busy", 1, longint'(tr_busy[1]), 64'h7_FFFE);

    // Start and coefficient load together: sample first, then the grant.
    clear_tr();
    start     = 1'b1;
    cload_req = 1'b1;
    cyc();
    start = 1'b0;
    repeat (30) cyc();
    cload_req = 1'b0;
    repeat (5) cyc();
    check("C_gnt_rise", 0, first_hi(tr_gnt[0]), 21);
    check("C_gnt_fall", 0, last_hi(tr_gnt[0]), 31);
    check("C_done", 0, longint'(tr_done[0]), 64'h1 << 19);
    check("C_gnt_rise", 1, first_hi(tr_gnt[1]), 20);
    check("C_gnt_fall", 1, last_hi(tr_gnt[1]), 31);

    // Dropped start mid-sample, then overrun clear.
    clear_tr();
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (9) cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (14) cyc();
    ovr_clr = 1'b1;
    cyc();
    ovr_clr = 1'b0;
    repeat (5) cyc();
    for (int i = 0; i < 2; i++) begin
      check("D_ovr_c10", i, longint'(tr_ovr[i][10]), 0);
      check("D_ovr_c11", i, longint'(tr_ovr[i][11]), 1);
      check("D_ovr_c25", i, longint'(tr_ovr[i][25]), 1);
      check("D_ovr_c26", i, longint'(tr_ovr[i][26]), 0);
    end
    check("D_done", 0, longint'(tr_done[0]), 64'h1 << 19);
    check("D_done", 1, longint'(tr_done[1]), 64'h1 << 18);

    // Reset during accumulation, then a fresh sample.
    clear_tr();
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (7) cyc();
    resetn = 1'b0;
    #1;
    check_zero("E_async");
    cyc();
    resetn = 1'b1;
    repeat (5) cyc();
    check("E_no_done", 0, longint'(tr_done[0]), 0);
    check("E_no_done", 1, longint'(tr_done[1]), 0);
    clear_tr();
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (24) cyc();
    check("E_done", 0, longint'(tr_done[0]), 64'h1 << 19);
    check("E_en_first", 0, first_hi(tr_en[0]), 3);
    check("E_done", 1, longint'(tr_done[1]), 64'h1 << 18);

    // Starts hammered during a coefficient load.
    cload_req = 1'b1;
    repeat (2) cyc();
    start = 1'b1;
    repeat (300) cyc();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("F_overrun", i, longint'(d_ovr[i]), 1);
`ifdef DA_SEQ_OVR_CNT_EN
      check("F_cnt_sat", i, longint'(d_cnt[i]), 255);
`endif
    end
    start   = 1'b1;
    ovr_clr = 1'b1;
    cyc();
    start   = 1'b0;
    ovr_clr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("F_ovr_set_wins", i, longint'(d_ovr[i]), 1);
`ifdef DA_SEQ_OVR_CNT_EN
      check("F_cnt_one", i, longint'(d_cnt[i]), 1);
`endif
    end
    cload_req = 1'b0;
    repeat (3) cyc();
    ovr_clr = 1'b1;
    cyc();
    ovr_clr = 1'b0;
    for (int i = 0; i < 2; i++) check("F_ovr_cleared", i, longint'(d_ovr[i]), 0);

    // Random traffic, including rare asynchronous resets.
    for (int n = 0; n < 3000; n++) begin
      start   = ($urandom_range(0, 7) == 0);
      ovr_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 15) == 0) cload_req = ~cload_req;
      resetn = ($urandom_range(0, 499) != 0);
      cyc();
      resetn = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
